// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and types for the pipeline sequencer
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // bit0 PC .. bit5 WB; WB is never held
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] DEF_EXC_VECTOR     = 32'h0000_0020;
  localparam logic [31:0] DEF_TIMEOUT_VECTOR = 32'h0000_0040;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_stall_watchdog.sv
// rtl/pipe_stall_watchdog.sv - consecutive-stall counter with expiry strobe
module pipe_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic req_any,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = run && (req_any == STOP) && (cnt_q == CNT_W'(STALL_TIMEOUT - 1));

  // any break in the freeze (idle cycle, flush, or expiry itself) restarts the count
  always_comb begin
    cnt_d = '0;
    if (run && (req_any == STOP) && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall merge, flush sequencing and redirect PC for the 5-stage core
// Optional stalled-cycle counter enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = DEF_EXC_VECTOR,
  parameter logic [31:0] TIMEOUT_VECTOR = DEF_TIMEOUT_VECTOR,
  parameter int          STALL_TIMEOUT  = 1024,
  parameter int          CNT_W          = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  logic [31:0] epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        timeout,
  output logic [31:0] stall_cycles
);

  pipe_state_e state_q, state_d;
  logic        flush_q, flush_d;
  logic        timeout_q, timeout_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [5:0]  stall_vec;
  logic        req_any;
  logic        wd_expire;

  assign req_any = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // latest requesting stage wins; nothing is held while the flush drains
  always_comb begin
    stall_vec = STALL_NONE;
    if (state_q == ST_RUN) begin
      if (stallreq_mem)     stall_vec = STALL_MEM;
      else if (stallreq_ex) stall_vec = STALL_EX;
      else if (stallreq_id) stall_vec = STALL_ID;
      else if (stallreq_if) stall_vec = STALL_IF;
    end
  end

  pipe_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == ST_RUN),
    .req_any (req_any),
    .expire  (wd_expire)
  );

  always_comb begin
    state_d   = ST_RUN;
    flush_d   = NO_STOP;
    timeout_d = NO_STOP;
    new_pc_d  = 32'h0;
    case (state_q)
      ST_RUN: begin
        // an exception outranks a simultaneous watchdog expiry
        if (excp_valid) begin
          state_d  = ST_FLUSH;
          flush_d  = 1'b1;
          new_pc_d = excp_is_eret ? epc_i : EXC_VECTOR;
        end else if (wd_expire) begin
          state_d   = ST_FLUSH;
          flush_d   = 1'b1;
          timeout_d = 1'b1;
          new_pc_d  = TIMEOUT_VECTOR;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
      new_pc_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
      new_pc_q  <= new_pc_d;
    end
  end

  assign stall   = stall_vec;
  assign flush   = flush_q;
  assign timeout = timeout_q;
  assign new_pc  = new_pc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_vec != STALL_NONE) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid, excp_is_eret;
  logic [31:0] epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        timeout;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .EXC_VECTOR     (32'h0000_0020),
    .TIMEOUT_VECTOR (32'h0000_0040),
    .STALL_TIMEOUT  (8),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_is_eret (excp_is_eret),
    .epc_i        (epc_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .timeout      (timeout),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excp_valid   = 1'b0;
    excp_is_eret = 1'b0;
    epc_i        = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got %b exp %b", stall, 6'b000000); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_priority();
    stallreq_id = 1'b1; stallreq_mem = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_id_mem got %b exp 011111", stall); end
    stallreq_mem = 1'b0; #1;
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL prio_id got %b exp 000111", stall); end
    stallreq_ex = 1'b1; stallreq_if = 1'b1; #1;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL prio_if_id_ex got %b exp 001111", stall); end
    stallreq_ex = 1'b0; stallreq_id = 1'b0; #1;
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL prio_if got %b exp 000011", stall); end
    stallreq_if = 1'b0; #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL prio_none got %b exp 000000", stall); end
    step();
  endtask

  task automatic test_exception();
    stallreq_ex = 1'b1; excp_valid = 1'b1; excp_is_eret = 1'b0; #1;
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL exc_pre_stall got %b exp 001111", stall); end
    step();
    excp_valid = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL exc_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'h20) begin errors++; $display("FAIL exc_new_pc got %h exp 00000020", new_pc); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL exc_flush_stall got %b exp 000000", stall); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL exc_timeout got %b exp 0", timeout); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_after_flush got %b exp 0", flush); end
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL exc_resume_stall got %b exp 001111", stall); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL exc_after_new_pc got %h exp 0", new_pc); end
    stallreq_ex = 1'b0;
    step();
  endtask

  task automatic test_eret_ignored();
    excp_valid = 1'b1; excp_is_eret = 1'b1; epc_i = 32'h0000_1234;
    step();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL eret_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'h0000_1234) begin errors++; $display("FAIL eret_new_pc got %h exp 00001234", new_pc); end
    excp_is_eret = 1'b0;
    step();
    excp_valid = 1'b0;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL eret_second_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL eret_second_new_pc got %h exp 0", new_pc); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL eret_late_flush got %b exp 0", flush); end
  endtask

  task automatic test_watchdog();
    stallreq_if = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++; if (flush !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL wd_early cycle %0d flush %b timeout %b exp 0 0", i, flush, timeout); end
    end
    step();
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout got %b exp 1", timeout); end
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL wd_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'h40) begin errors++; $display("FAIL wd_new_pc got %h exp 00000040", new_pc); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL wd_flush_stall got %b exp 000000", stall); end
    step();
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_pulse_len got %b exp 0", timeout); end
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL wd_resume_stall got %b exp 000011", stall); end
    stallreq_if = 1'b0;
    step();
  endtask

  task automatic test_watchdog_gap();
    stallreq_if = 1'b1;
    for (int i = 1; i <= 4; i++) step();
    stallreq_if = 1'b0;
    step();
    stallreq_if = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_gap_early cycle %0d timeout %b exp 0", i, timeout); end
    end
    step();
    checks++; if (timeout !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL wd_gap_fire timeout %b flush %b exp 1 1", timeout, flush); end
    stallreq_if = 1'b0;
    step();
  endtask

  task automatic test_coincide();
    stallreq_mem = 1'b1;
    for (int i = 1; i <= 7; i++) step();
    excp_valid = 1'b1; excp_is_eret = 1'b0;
    step();
    excp_valid = 1'b0; stallreq_mem = 1'b0;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL coinc_flush got %b exp 1", flush); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL coinc_timeout got %b exp 0", timeout); end
    checks++; if (new_pc !== 32'h20) begin errors++; $display("FAIL coinc_new_pc got %h exp 00000020", new_pc); end
    step();
  endtask

  task automatic test_reset_mid_flush();
    excp_valid = 1'b1;
    step();
    excp_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_flush flush %b new_pc %h exp 0 0", flush, new_pc); end
    step();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_mid_flush_after got %b exp 0", flush); end
  endtask

  task automatic test_perf();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      stallreq_id = (i != 5);
      step();
    end
    stallreq_id = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    checks++; if (stall_cycles !== 32'd10) begin errors++; $display("FAIL perf_count got %0d exp 10", stall_cycles); end
    force dut.stall_cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cycles_q;
    stallreq_id = 1'b1;
    step();
    stallreq_id = 1'b0;
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL perf_wrap got %h exp 00000000", stall_cycles); end
`else
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL perf_absent got %0d exp 0", stall_cycles); end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_exception();
    test_eret_ignored();
    test_watchdog();
    test_watchdog_gap();
    test_coincide();
    test_reset_mid_flush();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges per-stage stall requests into the shared 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences pipeline flushes for exceptions and ERET, and supplies the redirect PC. A stall watchdog forces a recovery flush when the pipeline stays frozen too long.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for exceptions
TIMEOUT_VECTOR, 32'h0000_0040, redirect PC on stall-watchdog expiry
STALL_TIMEOUT, 1024, consecutive stalled cycles before watchdog fires (>=2)
CNT_W, 11, watchdog counter width; must hold STALL_TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset
stallreq_if  in  1  fetch stall request (I-side wait)
stallreq_id  in  1  decode stall request (load-use)
stallreq_ex  in  1  execute stall request (multicycle op)
stallreq_mem  in  1  memory stall request (D-side wait)
excp_valid  in  1  exception committed in MEM this cycle
excp_is_eret  in  1  qualifies excp_valid: return from exception
epc_i  in  32  return address for ERET
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
flush  out  1  clear all pipeline registers
new_pc  out  32  redirect PC, valid while flush=1
timeout  out  1  one-cycle pulse when the watchdog fires
stall_cycles  out  32  total stalled-cycle count (optional feature)

Behaviour:
- Reset: one clock, synchronous, active-low: rst=0 sampled at posedge resets. Reset values: stall=0, flush=0, new_pc=0, timeout=0, stall_cycles=0, state=RUN, watchdog count=0. Reset mid-FLUSH aborts the flush.
- Stall vector is combinational from the request inputs and the state, with zero latency. The highest (latest) requesting stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
  - WB (bit5) is never stalled.
- FSM states: RUN, FLUSH.
- RUN → FLUSH at a posedge when excp_valid=1 or the watchdog expires.
  - Latched new_pc: epc_i if excp_is_eret, else EXC_VECTOR; TIMEOUT_VECTOR on watchdog expiry.
  - If excp_valid and watchdog expiry coincide, the exception wins and timeout is not pulsed.
- FLUSH lasts exactly 1 cycle, then unconditionally returns to RUN.
  - flush=1 and new_pc is held; stall is forced to 0 regardless of requests.
  - excp_valid arriving while in FLUSH is ignored, because its instruction is being flushed.
- flush and new_pc are registered: visible the cycle after excp_valid is sampled. new_pc returns to 0 in RUN.
- Watchdog counter:
  - In RUN, increments each cycle any stallreq_* is 1.
  - Clears on a cycle with no request, and in FLUSH.
  - When count == STALL_TIMEOUT-1 and a request is still present, it expires: timeout pulses 1 cycle (coincident with flush) and the counter clears.
- Stall requests are not registered or gated here. Requesters hold a request until their condition resolves.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: stall_cycles is a 32-bit counter, incremented each cycle stall!=0. It wraps 32'hFFFF_FFFF → 0 and is cleared only by reset.
- Undefined: the counter logic is absent and stall_cycles is tied to 32'h0. The port remains, so the interface is unchanged.

Decomposition:
- Shared defines header additions: Stop/NoStop, the four stall-vector encodings, the FSM state encodings RUN/FLUSH, and EXC_VECTOR/TIMEOUT_VECTOR defaults.
- One natural sub-module, pipe_stall_watchdog, contains the counter plus expiry pulse. The priority encoder and FSM stay inline.

Test Plan:
- Reset and idle: hold rst=0 for 2 cycles, release, no requests → stall=0, flush=0, new_pc=0, timeout=0.
- Priority: stallreq_id=1 and stallreq_mem=1 together → stall=6'b011111 in the same cycle. Drop mem → 6'b000111. Drop id → 0.
- Exception redirect: excp_valid=1, excp_is_eret=0 for one cycle while stallreq_ex=1 → next cycle flush=1, new_pc=32'h20, stall=0. The following cycle flush=0 and stall=6'b001111 resumes.
- ERET and ignored exception: excp_valid=1, excp_is_eret=1, epc_i=32'h0000_1234 → next cycle new_pc=32'h1234. A second excp_valid asserted during that FLUSH cycle produces no second flush.
- Watchdog, with STALL_TIMEOUT=8:
  - stallreq_if held high → on the 8th stalled cycle's posedge, timeout=1 and flush=1 with new_pc=32'h40.
  - A single-cycle request gap at cycle 5 restarts the count, so the expiry shifts accordingly.
- Perf counter, with PIPE_CTRL_PERF_EN defined: 10 stalled cycles → stall_cycles=10. Force the counter to 32'hFFFF_FFFF, stall 1 cycle → 0. Without the macro, stall_cycles stays 0.
